// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl
// Brief    : Async FIFO read-side controller with a 2-entry output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int c_PTR_W = ADDR_WIDTH + 1;

  logic [c_PTR_W-1:0]    r_rd_ptr_bin;
  logic [c_PTR_W-1:0]    r_rd_ptr_gray;
  logic [c_PTR_W-1:0]    w_rd_ptr_bin_nxt;
  logic [c_PTR_W-1:0]    w_wr_ptr_bin;
  logic                  r_pending;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_issue;
  logic [2:0]            w_occupancy;

  // Bit i of a binary value is the XOR of all gray bits at or above i.
  always_comb begin
    w_wr_ptr_bin = '0;
    for (int i = 0; i < c_PTR_W; i++) begin
      w_wr_ptr_bin[i] = ^(wr_ptr_gray_sync >> i);
    end
  end

  assign w_rd_ptr_bin_nxt = r_rd_ptr_bin + {{(c_PTR_W-1){1'b0}}, 1'b1};
  assign w_empty          = (r_rd_ptr_gray == wr_ptr_gray_sync);
  assign w_pop            = out_valid & out_ready;

  // Words already held or in flight after this cycle's pop must leave a free slot.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
  assign w_issue     = !w_empty && !reset && !flush && (w_occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr_bin  <= '0;
      r_rd_ptr_gray <= '0;
      r_pending     <= 1'b0;
      r_count       <= 2'd0;
      r_head        <= '0;
      r_tail        <= '0;
    end else begin
      if (w_issue) begin
        r_rd_ptr_bin  <= w_rd_ptr_bin_nxt;
        r_rd_ptr_gray <= w_rd_ptr_bin_nxt ^ (w_rd_ptr_bin_nxt >> 1);
      end
      r_pending <= w_issue;
      case ({r_pending, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= mem_data_in;
          else                 r_tail <= mem_data_in;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= mem_data_in;
          end else begin
            r_head <= r_tail;
            r_tail <= mem_data_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_ptr_gray = r_rd_ptr_gray;
  assign read_addr   = r_rd_ptr_bin[ADDR_WIDTH-1:0];
  assign read_enable = w_issue;
  assign out_valid   = (r_count != 2'd0);
  assign out_data    = (r_count != 2'd0) ? r_head : '0;
  assign empty       = w_empty;
  assign fill_level  = w_wr_ptr_bin - r_rd_ptr_bin;

  a_no_overflow_capture : assert property (@(posedge clk) disable iff (reset || flush)
    !(r_pending && (r_count == 2'd2) && !w_pop));
  a_count_bound : assert property (@(posedge clk) disable iff (reset || flush)
    r_count <= 2'd2);

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_ctrl
// Brief    : Scoreboard bench for fifo_read_ctrl with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_ctrl;

  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [AW:0]   wr_ptr_gray_sync;
  logic [AW:0]   rd_ptr_gray;
  logic [AW-1:0] read_addr;
  logic          read_enable;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          empty;
  logic [AW:0]   fill_level;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] sb [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            wr_total = 0;
  int            consumed = 0;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_ptr_gray_sync(wr_ptr_gray_sync), .rd_ptr_gray(rd_ptr_gray),
    .read_addr(read_addr), .read_enable(read_enable), .mem_data_in(mem_data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .empty(empty), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after read_enable.
  always @(posedge clk) if (read_enable) mem_data_in <= mem[read_addr];

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    logic [AW:0] wb;
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      wb = wr_total[AW:0];
      d  = $urandom;
      mem[wb[AW-1:0]] = d;
      sb.push_back(d);
      wr_total++;
    end
    wb = wr_total[AW:0];
    wr_ptr_gray_sync = bin2gray(wb);
  endtask

  // Consumer side: every accepted word must be the oldest one written.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        check("data", {32'd0, out_data}, {32'd0, e});
        consumed++;
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_ptr_gray_sync = '0;
    tick(); tick();
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_re", {63'd0, read_enable}, 64'd0);
    check("rst_gray", {56'd0, rd_ptr_gray}, 64'd0);
    check("rst_fill", {56'd0, fill_level}, 64'd0);
    reset = 1'b0;
    tick();

    // Three words, consumer always ready.
    out_ready = 1'b1;
    push_words(3);
    #1;
    check("t2_re0", {63'd0, read_enable}, 64'd1);
    check("t2_addr0", {57'd0, read_addr}, 64'd0);
    tick();
    check("t2_re1", {63'd0, read_enable}, 64'd1);
    check("t2_addr1", {57'd0, read_addr}, 64'd1);
    tick();
    check("t2_re2", {63'd0, read_enable}, 64'd1);
    check("t2_addr2", {57'd0, read_addr}, 64'd2);
    check("t2_valid", {63'd0, out_valid}, 64'd1);
    tick();
    check("t2_re3", {63'd0, read_enable}, 64'd0);
    check("t2_empty", {63'd0, empty}, 64'd1);
    repeat (3) tick();
    check("t2_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: only two words may be pulled out of memory.
    out_ready = 1'b0;
    push_words(4);
    repeat (5) tick();
    check("t3_fill", {56'd0, fill_level}, 64'd2);
    check("t3_re", {63'd0, read_enable}, 64'd0);
    check("t3_valid", {63'd0, out_valid}, 64'd1);
    check("t3_gray", {56'd0, rd_ptr_gray}, {56'd0, bin2gray(8'd5)});
    out_ready = 1'b1;
    repeat (6) tick();
    check("t3_sb", 64'(sb.size()), 64'd0);
    check("t3_empty", {63'd0, empty}, 64'd1);

    // Pointer wrap: advance to 126, then read across the end of memory.
    push_words(119);
    repeat (125) tick();
    check("t4_pre_fill", {56'd0, fill_level}, 64'd0);
    check("t4_pre_gray", {56'd0, rd_ptr_gray}, {56'd0, bin2gray(8'd126)});
    push_words(4);
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [AW:0] b;
      b = 8'(126 + k);
      check("t4_addr", {57'd0, read_addr}, {57'd0, b[AW-1:0]});
      check("t4_gray", {56'd0, rd_ptr_gray}, {56'd0, bin2gray(b)});
      tick();
    end
    check("t4_gray_msb", {63'd0, rd_ptr_gray[AW]}, 64'd1);
    repeat (5) tick();
    check("t4_sb", 64'(sb.size()), 64'd0);

    // Flush with a word buffered and a read in flight.
    out_ready = 1'b0;
    push_words(5);
    repeat (2) tick();
    flush = 1'b1;
    wr_total = 0; consumed = 0; sb.delete(); wr_ptr_gray_sync = '0;
    #1;
    check("t5_re", {63'd0, read_enable}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("t5_valid", {63'd0, out_valid}, 64'd0);
    check("t5_gray", {56'd0, rd_ptr_gray}, 64'd0);
    check("t5_fill", {56'd0, fill_level}, 64'd0);
    tick();
    check("t5_quiet", {63'd0, out_valid}, 64'd0);

    // Random producer rate and consumer stalls.
    for (int c = 0; c < 10000; c++) begin
      int n;
      out_ready = ($urandom_range(0, 3) != 0);
      n = $urandom_range(0, 2);
      if (wr_total - consumed + n <= (1 << AW)) push_words(n);
      #1;
      check("t6_empty", {63'd0, empty}, {63'd0, (fill_level == '0)});
      tick();
    end
    out_ready = 1'b1;
    repeat (140) tick();
    check("t6_sb", 64'(sb.size()), 64'd0);
    check("t6_fill", {56'd0, fill_level}, 64'd0);
    check("t6_valid", {63'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
